// File: rtl/rseq_pkg.sv
// ============================================================================
// Module   : rseq_pkg
// Purpose  : Shared constants and state encoding for the micro-op ROM sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rseq_pkg;

    localparam int VEC_W  = 8;
    localparam int ADDR_W = 3;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t DRAIN  = 2'd1;
    localparam state_t ISSUE  = 2'd2;
    localparam state_t FINISH = 2'd3;

    localparam logic [ADDR_W-1:0] INT_START  = 3'd0;
    localparam logic [ADDR_W-1:0] INT_LAST   = 3'd3;
    localparam logic [ADDR_W-1:0] IRET_START = 3'd4;
    localparam logic [ADDR_W-1:0] IRET_LAST  = 3'd6;

endpackage

`default_nettype wire

// File: rtl/rseq_addr_cnt.sv
// ============================================================================
// Module   : rseq_addr_cnt
// Purpose  : Loadable ROM address counter with hold and terminal-word compare.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rseq_addr_cnt
    import rseq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [ADDR_W-1:0] i_load_end,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_at_end
);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_end;

    assign o_addr   = r_addr;
    assign o_at_end = (r_addr == r_end);

    // The terminal guard keeps the counter from ever stepping past the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_end  <= '0;
        end else if (i_load) begin
            r_addr <= i_load_addr;
            r_end  <= i_load_end;
        end else if (i_step && !o_at_end) begin
            r_addr <= r_addr + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rseq_ctrl.sv
// ============================================================================
// Module   : rseq_ctrl
// Purpose  : Sequencer for the interrupt/exception/IRET micro-op ROM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rseq_ctrl
    import rseq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exc_req,
    input  logic [VEC_W-1:0]  exc_vec,
    input  logic              int_req,
    input  logic [VEC_W-1:0]  int_vec,
    input  logic              if_flag,
    input  logic              iret_dec,
    input  logic              pipe_empty,
    input  logic              dec_stall,
    output logic [ADDR_W-1:0] rseq_addr,
    output logic              rseq_oe,
    output logic [VEC_W-1:0]  rseq_vec,
    output logic              fetch_stall,
    output logic              exc_ack,
    output logic              int_ack,
    output logic              rseq_done
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_load;
    logic [ADDR_W-1:0] w_load_addr;
    logic [ADDR_W-1:0] w_load_end;
    logic              w_step;
    logic              w_take_exc;
    logic              w_take_int;
    logic              w_at_end;
    logic              w_oe_nxt;
    logic              w_done_nxt;
    logic              w_fs_nxt;
    logic [VEC_W-1:0]  w_vec_nxt;

    rseq_addr_cnt u_addr_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_load_addr (w_load_addr),
        .i_load_end  (w_load_end),
        .i_step      (w_step),
        .o_addr      (rseq_addr),
        .o_at_end    (w_at_end)
    );

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            rseq_oe     <= 1'b0;
            rseq_done   <= 1'b0;
            fetch_stall <= 1'b0;
            exc_ack     <= 1'b0;
            int_ack     <= 1'b0;
            rseq_vec    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            rseq_oe     <= w_oe_nxt;
            rseq_done   <= w_done_nxt;
            fetch_stall <= w_fs_nxt;
            exc_ack     <= w_take_exc;
            int_ack     <= w_take_int;
            rseq_vec    <= w_vec_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_addr = INT_START;
        w_load_end  = INT_LAST;
        w_step      = 1'b0;
        w_take_exc  = 1'b0;
        w_take_int  = 1'b0;
        case (r_state)
            IDLE: begin
                if (exc_req) begin
                    w_take_exc  = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = DRAIN;
                end else if (int_req && if_flag) begin
                    w_take_int  = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = DRAIN;
                end else if (iret_dec) begin
                    w_load      = 1'b1;
                    w_load_addr = IRET_START;
                    w_load_end  = IRET_LAST;
                    w_state_nxt = ISSUE;
                end
            end
            DRAIN: begin
                if (exc_req) begin
                    w_take_exc = 1'b1;
                    w_load     = 1'b1;
                end else if (pipe_empty) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // A nested fault abandons the partial sequence and restarts the drain.
                if (exc_req) begin
                    w_take_exc  = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = DRAIN;
                end else if (!dec_stall) begin
                    if (w_at_end) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_oe_nxt   = (w_state_nxt == ISSUE);
        w_done_nxt = (w_state_nxt == FINISH);
        w_fs_nxt   = (w_state_nxt != IDLE);
        w_vec_nxt  = rseq_vec;
        if (w_take_exc) begin
            w_vec_nxt = exc_vec;
        end else if (w_take_int) begin
            w_vec_nxt = int_vec;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rseq_ctrl.sv
// ============================================================================
// Module   : tb_rseq_ctrl
// Purpose  : Self-checking bench for rseq_ctrl against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rseq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       exc_req = 1'b0;
    logic [7:0] exc_vec = 8'h00;
    logic       int_req = 1'b0;
    logic [7:0] int_vec = 8'h00;
    logic       if_flag = 1'b0;
    logic       iret_dec = 1'b0;
    logic       pipe_empty = 1'b0;
    logic       dec_stall = 1'b0;
    logic [2:0] rseq_addr;
    logic       rseq_oe;
    logic [7:0] rseq_vec;
    logic       fetch_stall;
    logic       exc_ack;
    logic       int_ack;
    logic       rseq_done;

    int total = 0;
    int bad   = 0;

    rseq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exc_req     (exc_req),
        .exc_vec     (exc_vec),
        .int_req     (int_req),
        .int_vec     (int_vec),
        .if_flag     (if_flag),
        .iret_dec    (iret_dec),
        .pipe_empty  (pipe_empty),
        .dec_stall   (dec_stall),
        .rseq_addr   (rseq_addr),
        .rseq_oe     (rseq_oe),
        .rseq_vec    (rseq_vec),
        .fetch_stall (fetch_stall),
        .exc_ack     (exc_ack),
        .int_ack     (int_ack),
        .rseq_done   (rseq_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a sequence is a base address plus a word position and length.
    bit       m_drain, m_issue, m_finish, m_eack, m_iack;
    int       m_base, m_pos, m_len;
    logic [7:0] m_vec;

    task automatic model_reset();
        m_drain = 0; m_issue = 0; m_finish = 0; m_eack = 0; m_iack = 0;
        m_base = 0; m_pos = 0; m_len = 4; m_vec = 8'h00;
    endtask

    task automatic start_seq(input int base, input int len);
        m_base = base; m_pos = 0; m_len = len;
    endtask

    task automatic model_tick();
        bit idle;
        if (!rst_n) begin
            model_reset();
            return;
        end
        idle   = !(m_drain || m_issue || m_finish);
        m_eack = 0;
        m_iack = 0;
        if (idle) begin
            if (exc_req) begin
                m_eack = 1; m_vec = exc_vec; start_seq(0, 4); m_drain = 1;
            end else if (int_req && if_flag) begin
                m_iack = 1; m_vec = int_vec; start_seq(0, 4); m_drain = 1;
            end else if (iret_dec) begin
                start_seq(4, 3); m_issue = 1;
            end
        end else if (m_finish) begin
            m_finish = 0;
        end else if (exc_req) begin
            m_eack = 1; m_vec = exc_vec; start_seq(0, 4);
            m_issue = 0; m_drain = 1;
        end else if (m_drain) begin
            if (pipe_empty) begin
                m_drain = 0; m_issue = 1;
            end
        end else if (!dec_stall) begin
            if (m_pos == m_len - 1) begin
                m_issue = 0; m_finish = 1;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic compare_all();
        chk("addr", rseq_addr, m_base + m_pos);
        chk("oe", rseq_oe, m_issue);
        chk("vec", rseq_vec, m_vec);
        chk("fetch_stall", fetch_stall, m_drain | m_issue | m_finish);
        chk("exc_ack", exc_ack, m_eack);
        chk("int_ack", int_ack, m_iack);
        chk("done", rseq_done, m_finish);
    endtask

    // Requesters drop their level request in the cycle they see the ack.
    task automatic step();
        @(posedge clk);
        model_tick();
        @(negedge clk);
        compare_all();
        if (exc_ack) exc_req = 1'b0;
        if (int_ack) int_req = 1'b0;
        iret_dec = 1'b0;
    endtask

    task automatic run_until_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            step();
            if (!fetch_stall && !exc_req && !int_req) return;
        end
        chk("idle_timeout", fetch_stall, 0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_oe", rseq_oe, 0);
        chk("rst_addr", rseq_addr, 0);
        chk("rst_fetch_stall", fetch_stall, 0);
        chk("rst_vec", rseq_vec, 0);
        model_reset();
        exc_req = 1'b0; int_req = 1'b0; iret_dec = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int n;
        model_reset();
        #2 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();

        // Interrupt, no stalls, pipe drains after 3 cycles.
        int_req = 1'b1; if_flag = 1'b1; int_vec = 8'h20; pipe_empty = 1'b0; dec_stall = 1'b0;
        for (int i = 0; i < 3; i++) step();
        pipe_empty = 1'b1;
        run_until_idle(20);
        step();

        // IRET with two stall cycles on word 5.
        iret_dec = 1'b1;
        step();
        n = 0;
        for (int i = 0; i < 12 && fetch_stall; i++) begin
            dec_stall = (rseq_addr == 3'd5) && (n < 2);
            if (dec_stall) n++;
            step();
        end
        dec_stall = 1'b0;
        step();

        // Exception and interrupt together: exception first, interrupt after.
        exc_req = 1'b1; exc_vec = 8'h0E; int_req = 1'b1; int_vec = 8'h21; if_flag = 1'b1;
        run_until_idle(40);
        step();

        // Masked interrupt is never acknowledged.
        int_req = 1'b1; if_flag = 1'b0; int_vec = 8'h33;
        for (int i = 0; i < 6; i++) step();
        int_req = 1'b0; if_flag = 1'b1;
        step();

        // Nested fault while issuing word 2.
        exc_req = 1'b1; exc_vec = 8'h40;
        for (int i = 0; i < 12 && !(rseq_oe && rseq_addr == 3'd2); i++) step();
        exc_req = 1'b1; exc_vec = 8'h41;
        run_until_idle(30);

        // Reset while issuing word 5.
        iret_dec = 1'b1;
        step();
        for (int i = 0; i < 6 && rseq_addr != 3'd5; i++) step();
        reset_pulse();

        for (int i = 0; i < 3000; i++) begin
            if (!exc_req && $urandom_range(0, 19) == 0) begin
                exc_req = 1'b1; exc_vec = 8'($urandom);
            end
            if (!int_req && $urandom_range(0, 11) == 0) begin
                int_req = 1'b1; int_vec = 8'($urandom);
            end
            if_flag    = ($urandom_range(0, 3) != 0);
            iret_dec   = ($urandom_range(0, 9) == 0);
            pipe_empty = ($urandom_range(0, 1) == 1);
            dec_stall  = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 499) == 0) reset_pulse();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rseq_ctrl.md
# rseq_ctrl

Sequencer that drives the 8-word, 128-bit interrupt/exception/IRET micro-op ROM. It accepts exception requests, external interrupts and decoded IRETs, drains the pipeline when needed, and steps the ROM address through the selected micro-sequence. Stepping is gated by the decode-stage stall so each 128-bit word is consumed exactly once. It sits between the decode/exception logic (upstream) and the ROM plus decode-stage uop mux (downstream).

## Interface
- INT_START, 3'd0: first ROM word of the interrupt/exception sequence.
- INT_LAST, 3'd3: last ROM word of the interrupt/exception sequence.
- IRET_START, 3'd4: first ROM word of the IRET sequence.
- IRET_LAST, 3'd6: last ROM word of the IRET sequence.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- exc_req  in  1  exception raised (level, held until exc_ack).
- exc_vec  in  8  exception vector, valid with exc_req.
- int_req  in  1  external interrupt (level, held until int_ack).
- int_vec  in  8  interrupt vector, valid with int_req.
- if_flag  in  1  EFLAGS.IF; int_req is ignored when 0.
- iret_dec  in  1  IRET decoded this cycle (1-cycle pulse).
- pipe_empty  in  1  all stages past decode are drained.
- dec_stall  in  1  decode cannot accept a uop this cycle.
- rseq_addr  out  3  ROM address.
- rseq_oe  out  1  ROM output enable; also the uop-mux select (ROM word valid).
- rseq_vec  out  8  latched vector; immediate for the ROM uops.
- fetch_stall  out  1  holds fetch/decode while a sequence is pending or active.
- exc_ack  out  1  1-cycle pulse when an exception is accepted.
- int_ack  out  1  1-cycle pulse when an interrupt is accepted.
- rseq_done  out  1  1-cycle pulse after the last word is consumed.

## Operation
- States: IDLE, DRAIN, ISSUE, FINISH.
- Reset values: state IDLE, rseq_addr 0, rseq_vec 0, all 1-bit outputs 0.
- In IDLE, priority is exc_req > (int_req & if_flag) > iret_dec. Only one request is accepted per cycle.
- Accepting exc_req:
  - Pulses exc_ack.
  - Latches exc_vec into rseq_vec.
  - Loads end_q with INT_LAST and rseq_addr with INT_START.
  - Moves to DRAIN.
- Accepting int_req: identical to exc_req, but pulses int_ack and latches int_vec.
- Accepting iret_dec:
  - Loads end_q with IRET_LAST and rseq_addr with IRET_START.
  - Does not change rseq_vec.
  - Moves directly to ISSUE; no drain is needed.
- DRAIN: stays until pipe_empty is 1, then moves to ISSUE.
- ISSUE:
  - rseq_oe is 1.
  - If dec_stall is 1, rseq_addr holds.
  - If dec_stall is 0 and rseq_addr != end_q, rseq_addr increments.
  - If dec_stall is 0 and rseq_addr == end_q, moves to FINISH; rseq_addr holds.
- FINISH: rseq_done is 1 for one cycle, then the state returns to IDLE.
- fetch_stall is 1 in DRAIN, ISSUE and FINISH, and 0 in IDLE.
- Address arithmetic:
  - 3-bit counter.
  - end_q is always >= the start address, so the counter never wraps.
  - The counter is never incremented past end_q.
- exc_req in DRAIN or ISSUE (nested fault):
  - Pulses exc_ack and relatches the vector.
  - Reloads INT_START and INT_LAST.
  - Moves to DRAIN. The partial sequence is abandoned.
- exc_req in FINISH: ignored until IDLE.
- int_req and iret_dec are ignored outside IDLE.
- rst_n low in any state immediately forces the reset values, with no completion of the current sequence.

## Timing
- Exception/interrupt path:
  - Request accepted at edge N.
  - DRAIN during cycle N+1.
  - First ROM word driven one cycle after the edge that samples pipe_empty=1.
  - Minimum latency: request to first word is 2 cycles.
- IRET path: iret_dec sampled at edge N; first ROM word is valid during cycle N+1.
- Each word stays on rseq_addr/rseq_oe until a cycle with dec_stall=0. That is the consume handshake.
- Unstalled INT sequence: 4 ISSUE cycles, then 1 FINISH cycle.
- rseq_addr and rseq_oe are registered; the ROM output is valid in the same cycle.
- Acks and rseq_done are registered 1-cycle pulses.

## Structure
- Shared package rseq_pkg holds:
  - State encoding: IDLE=2'd0, DRAIN=2'd1, ISSUE=2'd2, FINISH=2'd3.
  - Sequence start/last constants.
  - Vector width 8.
- One natural sub-module: rseq_addr_cnt, a 3-bit loadable counter with hold and terminal compare. The FSM lives in rseq_ctrl.

## Test plan
- Reset then idle:
  - Stimulus: rst_n low, then high, no requests.
  - Required: all outputs 0, rseq_addr 0, fetch_stall 0.
- Interrupt, no stalls:
  - Stimulus: int_req=1, if_flag=1, int_vec=8'h20; pipe_empty=1 after 3 cycles.
  - Required: int_ack pulse; rseq_addr 0,1,2,3 on consecutive cycles with rseq_oe=1 and rseq_vec=8'h20; one rseq_done pulse; fetch_stall low afterwards.
- IRET with stall:
  - Stimulus: iret_dec pulse; dec_stall=1 for 2 cycles while addr=5.
  - Required: addr sequence 4,5,5,5,6; rseq_done follows the consumption of 6.
- Priority:
  - Stimulus: exc_req (vec 8'h0E) and int_req (vec 8'h21) in the same cycle.
  - Required: exc_ack only and rseq_vec=8'h0E. int_ack is pulsed only after exception rseq_done, once back in IDLE.
- Masking and nesting:
  - Stimulus: int_req with if_flag=0.
  - Required: no ack, stays IDLE.
  - Stimulus: exc_req during ISSUE at addr 2.
  - Required: exc_ack pulse, new vector latched, DRAIN, restart at addr 0.
- Reset mid-sequence:
  - Stimulus: rst_n low while ISSUE at addr 5.
  - Required: rseq_oe 0 and rseq_addr 0 immediately; IDLE after release.
